mem_bus_arbiter: RTL and testbench

Two-port arbiter sharing the single CPU-side memory bus (slow_ram interface) between an instruction-fetch requester (port 0) and a data requester (port 1).
- Accepts one request at a time and forwards its address, write data and write-enable to the memory.
- Waits for the memory's valid response, then returns the read data and a one-cycle ready pulse to the winning requester only.
- Sits between the cpu fetch/LSU units and slow_ram.

---
 rtl/mem_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the shared slow_ram bus. Port 0 carries instruction
// fetches and port 1 carries data accesses. One transaction is in flight at a
// time, and each one is bounded by a wait-cycle timeout.
// Optional feature: define ARB_ROUND_ROBIN_EN to get round-robin arbitration.
// When it is undefined, port 1 always wins over port 0.
module mem_bus_arbiter #(
  parameter int unsigned ADDRESS_WIDTH    = 20,
  parameter int unsigned DATA_WIDTH_SHIFT = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 255,
  localparam int unsigned DATA_WIDTH      = (2 ** DATA_WIDTH_SHIFT) * 8,
  localparam int unsigned BEAT_AW         = ADDRESS_WIDTH - DATA_WIDTH_SHIFT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  p0_valid_i,
  input  logic [BEAT_AW-1:0]    p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_data_i,
  input  logic                  p0_we_i,
  output logic [DATA_WIDTH-1:0] p0_data_o,
  output logic                  p0_ready_o,
  input  logic                  p1_valid_i,
  input  logic [BEAT_AW-1:0]    p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_data_i,
  input  logic                  p1_we_i,
  output logic [DATA_WIDTH-1:0] p1_data_o,
  output logic                  p1_ready_o,
  output logic [BEAT_AW-1:0]    mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_we_o,
  output logic                  mem_valid_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_valid_i,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  // The transaction aborts when the counter is at this value and no response arrives.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic [BEAT_AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [DATA_WIDTH-1:0] p0_data_q, p0_data_d;
  logic [DATA_WIDTH-1:0] p1_data_q, p1_data_d;
  logic                  p0_ready_q, p0_ready_d;
  logic                  p1_ready_q, p1_ready_d;
  logic                  timeout_q, timeout_d;
  logic                  grant;
`ifdef ARB_ROUND_ROBIN_EN
  logic                  rr_last_q, rr_last_d;
`endif

  // Winner selection; grant=1 means port 1.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (p0_valid_i && p1_valid_i) begin
      grant = ~rr_last_q;
    end else begin
      grant = p1_valid_i;
    end
`else
    grant = p1_valid_i;
`endif
  end

  // Next-state logic for the FSM and the registered bus outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wait_cnt_d  = wait_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_we_d    = mem_we_q;
    mem_valid_d = mem_valid_q;
    p0_data_d   = p0_data_q;
    p1_data_d   = p1_data_q;
    p0_ready_d  = 1'b0;
    p1_ready_d  = 1'b0;
    timeout_d   = timeout_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d   = rr_last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (p0_valid_i || p1_valid_i) begin
          owner_d     = grant;
          mem_addr_d  = grant ? p1_addr_i : p0_addr_i;
          mem_data_d  = grant ? p1_data_i : p0_data_i;
          mem_we_d    = grant ? p1_we_i : p0_we_i;
          mem_valid_d = 1'b1;
          wait_cnt_d  = '0;
          state_d     = StBusy;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d   = grant;
`endif
        end
      end
      StBusy: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        // A response on the last allowed cycle still counts as success.
        if (mem_valid_i || (wait_cnt_q == TimeoutLast)) begin
          mem_valid_d = 1'b0;
          state_d     = StDone;
          timeout_d   = timeout_q | ~mem_valid_i;
          if (owner_q) begin
            p1_data_d  = mem_valid_i ? mem_data_i : '0;
            p1_ready_d = 1'b1;
          end else begin
            p0_data_d  = mem_valid_i ? mem_data_i : '0;
            p0_ready_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      wait_cnt_q  <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      p0_data_q   <= '0;
      p1_data_q   <= '0;
      p0_ready_q  <= 1'b0;
      p1_ready_q  <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
      mem_valid_q <= mem_valid_d;
      p0_data_q   <= p0_data_d;
      p1_data_q   <= p1_data_d;
      p0_ready_q  <= p0_ready_d;
      p1_ready_q  <= p1_ready_d;
      timeout_q   <= timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign mem_we_o    = mem_we_q;
  assign mem_valid_o = mem_valid_q;
  assign p0_data_o   = p0_data_q;
  assign p1_data_o   = p1_data_q;
  assign p0_ready_o  = p0_ready_q;
  assign p1_ready_o  = p1_ready_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter, built with TIMEOUT_CYCLES=8.
// The expected values follow ARB_ROUND_ROBIN_EN when the bench is compiled with it.
module tb_mem_bus_arbiter;

  localparam int unsigned AW  = 20;
  localparam int unsigned DWS = 4;
  localparam int unsigned DW  = 128;
  localparam int unsigned BAW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           p0_valid = 1'b0, p1_valid = 1'b0;
  logic [BAW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0]  p0_wdata = '0, p1_wdata = '0;
  logic           p0_we = 1'b0, p1_we = 1'b0;
  logic [DW-1:0]  p0_rdata, p1_rdata;
  logic           p0_ready, p1_ready;
  logic [BAW-1:0] mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_we, mem_valid_o;
  logic [DW-1:0]  mem_rdata = '0;
  logic           mem_valid_i = 1'b0;
  logic           timeout;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_arbiter #(
    .ADDRESS_WIDTH   (AW),
    .DATA_WIDTH_SHIFT(DWS),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .p0_valid_i (p0_valid),
    .p0_addr_i  (p0_addr),
    .p0_data_i  (p0_wdata),
    .p0_we_i    (p0_we),
    .p0_data_o  (p0_rdata),
    .p0_ready_o (p0_ready),
    .p1_valid_i (p1_valid),
    .p1_addr_i  (p1_addr),
    .p1_data_i  (p1_wdata),
    .p1_we_i    (p1_we),
    .p1_data_o  (p1_rdata),
    .p1_ready_o (p1_ready),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_we_o   (mem_we),
    .mem_valid_o(mem_valid_o),
    .mem_data_i (mem_rdata),
    .mem_valid_i(mem_valid_i),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Waits for the grant, then pulses mem_valid_i on the lat-th BUSY cycle.
  // The task returns at the negedge of the DONE cycle.
  task automatic serve(input int lat, input logic [DW-1:0] rdata, input logic [BAW-1:0] eaddr,
                       input logic ewe, input logic [DW-1:0] ewdata, output int busy);
    int n = 0;
    busy = 0;
    while (!mem_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("grant_seen", mem_valid_o, 1);
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_valid_o) busy++;
      check_eq("busy_addr", mem_addr, eaddr);
      check_eq("busy_we", mem_we, ewe);
      check_eq("busy_wdata", mem_wdata, ewdata);
      if (c == lat) begin
        mem_valid_i = 1'b1;
        mem_rdata   = rdata;
      end
    end
    @(negedge clk);
    mem_valid_i = 1'b0;
    mem_rdata   = '0;
  endtask

  int busy;
  int grant_seen;
  int exp_grant;
  int n;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_mem_valid", mem_valid_o, 0);
    check_eq("rst_ready", {p0_ready, p1_ready}, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_p0_data", p0_rdata, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;

    // Reset while a p0 read is outstanding
    @(negedge clk);
    p0_valid = 1'b1;
    p0_addr  = 16'h0033;
    n = 0;
    while (!mem_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("midrst_busy", mem_valid_o, 1);
    #2 rst = 1'b1;
    #1 check_eq("midrst_async", mem_valid_o, 0);
    p0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midrst_no_ready", {p0_ready, p1_ready}, 0);
      check_eq("midrst_idle", mem_valid_o, 0);
    end

    // p0 read, 3-cycle memory latency
    p0_valid = 1'b1;
    p0_addr  = 16'h0010;
    p0_we    = 1'b0;
    serve(3, 128'hDEADBEEF_0000_0000_0000_0000_0000_0001, 16'h0010, 1'b0, 128'h0, busy);
    p0_valid = 1'b0;
    check_eq("rd_busy_cycles", busy, 3);
    check_eq("rd_p0_ready", p0_ready, 1);
    check_eq("rd_p0_data", p0_rdata, 128'hDEADBEEF_0000_0000_0000_0000_0000_0001);
    check_eq("rd_p1_ready", p1_ready, 0);
    check_eq("rd_mem_valid_off", mem_valid_o, 0);
    @(negedge clk);
    check_eq("rd_pulse_width", p0_ready, 0);

    // p1 write to the top beat address
    p1_valid = 1'b1;
    p1_addr  = 16'hFFFF;
    p1_wdata = '1;
    p1_we    = 1'b1;
    serve(2, 128'h5A5A, 16'hFFFF, 1'b1, '1, busy);
    p1_valid = 1'b0;
    p1_we    = 1'b0;
    check_eq("wr_busy_cycles", busy, 2);
    check_eq("wr_p1_ready", p1_ready, 1);
    check_eq("wr_p1_data", p1_rdata, 128'h5A5A);
    check_eq("wr_p0_ready", p0_ready, 0);
    check_eq("wr_p0_hold", p0_rdata, 128'hDEADBEEF_0000_0000_0000_0000_0000_0001);
    @(negedge clk);
    check_eq("wr_pulse_width", p1_ready, 0);

    // Both ports request continuously for four transactions
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    p0_valid = 1'b1;
    p0_addr  = 16'h0100;
    p0_wdata = 128'hAA;
    p1_valid = 1'b1;
    p1_addr  = 16'h0200;
    p1_wdata = 128'hBB;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_grant = t % 2;
`else
      exp_grant = 1;
`endif
      serve(1, 128'h100 + DW'(t), (exp_grant == 1) ? 16'h0200 : 16'h0100, 1'b0,
            (exp_grant == 1) ? 128'hBB : 128'hAA, busy);
      if (t == 3) begin
        p0_valid = 1'b0;
        p1_valid = 1'b0;
      end
      grant_seen = p1_ready ? 1 : 0;
      check_eq("arb_grant", grant_seen, exp_grant);
      check_eq("arb_one_ready", {1'b0, p0_ready} + {1'b0, p1_ready}, 1);
    end
    check_eq("arb_p1_data", p1_rdata, 128'h103);

    // mem_valid_i while IDLE is ignored
    @(negedge clk);
    mem_valid_i = 1'b1;
    mem_rdata   = 128'hBAD;
    @(negedge clk);
    mem_valid_i = 1'b0;
    mem_rdata   = '0;
    check_eq("idle_inj_ready", {p0_ready, p1_ready}, 0);
    check_eq("idle_inj_mem_valid", mem_valid_o, 0);
    check_eq("idle_inj_p1_hold", p1_rdata, 128'h103);
    @(negedge clk);
    check_eq("idle_inj_ready2", {p0_ready, p1_ready}, 0);

    // Response on the last allowed cycle counts as success
    p0_valid = 1'b1;
    p0_addr  = 16'h0055;
    p0_wdata = '0;
    serve(8, 128'hCAFE, 16'h0055, 1'b0, 128'h0, busy);
    p0_valid = 1'b0;
    check_eq("edge_busy_cycles", busy, 8);
    check_eq("edge_p0_ready", p0_ready, 1);
    check_eq("edge_p0_data", p0_rdata, 128'hCAFE);
    check_eq("edge_timeout", timeout, 0);
    @(negedge clk);
    check_eq("edge_timeout2", timeout, 0);

    // Memory never responds
    p0_valid = 1'b1;
    p0_addr  = 16'h0123;
    busy = 0;
    n = 0;
    while (!p0_ready && n < 30) begin
      @(negedge clk);
      if (mem_valid_o) busy++;
      n++;
    end
    p0_valid = 1'b0;
    check_eq("to_ready", p0_ready, 1);
    check_eq("to_busy_cycles", busy, 8);
    check_eq("to_p0_data", p0_rdata, 0);
    check_eq("to_timeout", timeout, 1);
    check_eq("to_p1_ready", p1_ready, 0);
    check_eq("to_p1_hold", p1_rdata, 128'h103);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("to_sticky", timeout, 1);
      check_eq("to_no_ready", p0_ready, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
